// File: rtl/exec_unit_if.sv
// Bundle between exec_unit and the instruction source / 4x8 register file.
// Carries the instruction handshake, the register-file read and write ports, and the flags.
interface exec_unit_if;
  // Handshake: an instruction transfers on a rising edge where instrValid && instrReady.
  // instrReady is high only while the unit is idle, and instr is ignored at other times.
  logic       instrValid;
  logic [7:0] instr;
  logic       instrReady;
  logic [1:0] sr1;
  logic [1:0] sr2;
  logic [7:0] rdData1;
  logic [7:0] rdData2;
  logic       write;
  logic [1:0] dr;
  logic [7:0] wrData;
  logic       flagZ;
  logic       flagC;
  logic       done;

  modport master (
    output instrValid, instr, rdData1, rdData2,
    input  instrReady, sr1, sr2, write, dr, wrData, flagZ, flagC, done
  );

  modport slave (
    input  instrValid, instr, rdData1, rdData2,
    output instrReady, sr1, sr2, write, dr, wrData, flagZ, flagC, done
  );
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back stage: read operands, run the ALU, write back one result.
// Define EXEC_MUL_EN to add an 8-cycle shift-add multiplier for opcode 9 (otherwise opcode 9 is a NOP).
module exec_unit (
  input  logic          clk,
  input  logic          reset,
  exec_unit_if.slave    bus,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
`ifdef EXEC_MUL_EN
    S_MUL  = 3'd3,
`endif
    S_WB   = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] res;
  logic       cout;
  logic       wr_op;
  logic [8:0] alu_sum;
  logic [7:0] alu_r;
  logic       alu_c;

  assign state_dbg = state;
  assign alu_sum   = {1'b0, a} + {1'b0, b};

`ifdef EXEC_MUL_EN
  assign wr_op = (op <= 4'h9);

  // prod holds {partial sum, unconsumed multiplier bits}; one multiplier bit retires per cycle.
  logic [15:0] prod;
  logic [2:0]  mul_cnt;
  logic [8:0]  mul_sum;
  logic [15:0] prod_next;
  assign mul_sum   = {1'b0, prod[15:8]} + (prod[0] ? {1'b0, a} : 9'h000);
  assign prod_next = {mul_sum, prod[7:1]};
`else
  assign wr_op = (op <= 4'h8);
`endif

  always_comb begin
    alu_r = 8'h00;
    alu_c = 1'b0;
    case (op)
      4'h0: begin alu_r = alu_sum[7:0]; alu_c = alu_sum[8]; end
      4'h1: begin alu_r = a - b; alu_c = (a < b); end
      4'h2: alu_r = a & b;
      4'h3: alu_r = a | b;
      4'h4: alu_r = a ^ b;
      4'h5: alu_r = ~a;
      4'h6: begin alu_r = {a[6:0], 1'b0}; alu_c = a[7]; end
      4'h7: begin alu_r = {1'b0, a[7:1]}; alu_c = a[0]; end
      4'h8: alu_r = b;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      op             <= 4'h0;
      a              <= 8'h00;
      b              <= 8'h00;
      res            <= 8'h00;
      cout           <= 1'b0;
      bus.instrReady <= 1'b1;
      bus.sr1        <= 2'b00;
      bus.sr2        <= 2'b00;
      bus.write      <= 1'b0;
      bus.dr         <= 2'b00;
      bus.wrData     <= 8'h00;
      bus.flagZ      <= 1'b0;
      bus.flagC      <= 1'b0;
      bus.done       <= 1'b0;
`ifdef EXEC_MUL_EN
      prod           <= 16'h0000;
      mul_cnt        <= 3'd0;
`endif
    end else begin
      bus.write <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instrValid) begin
            op             <= bus.instr[7:4];
            bus.sr1        <= bus.instr[3:2];
            bus.sr2        <= bus.instr[1:0];
            bus.instrReady <= 1'b0;
            state          <= S_READ;
          end
        end
        S_READ: begin
          a     <= bus.rdData1;
          b     <= bus.rdData2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res  <= alu_r;
          cout <= alu_c;
`ifdef EXEC_MUL_EN
          if (op == 4'h9) begin
            prod    <= {8'h00, b};
            mul_cnt <= 3'd0;
            state   <= S_MUL;
          end else
`endif
          begin
            // write/done are registered so they rise exactly in the WB cycle.
            bus.done  <= 1'b1;
            bus.write <= wr_op;
            if (wr_op) begin
              bus.dr     <= bus.sr1;
              bus.wrData <= alu_r;
            end
            state <= S_WB;
          end
        end
`ifdef EXEC_MUL_EN
        S_MUL: begin
          prod    <= prod_next;
          mul_cnt <= mul_cnt + 3'd1;
          if (mul_cnt == 3'd7) begin
            res        <= prod_next[7:0];
            cout       <= |prod_next[15:8];
            bus.dr     <= bus.sr1;
            bus.wrData <= prod_next[7:0];
            bus.write  <= 1'b1;
            bus.done   <= 1'b1;
            state      <= S_WB;
          end
        end
`endif
        S_WB: begin
          if (wr_op) begin
            bus.flagZ <= (res == 8'h00);
            bus.flagC <= cout;
          end
          bus.instrReady <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit with a behavioural register file and a write scoreboard.
// Honors EXEC_MUL_EN the same way as the design for MUL timing and results.
module tb_exec_unit;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;
  exec_unit_if bus();

  exec_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reads are combinational; preload port used only while the unit is idle.
  logic [7:0] rf [4];
  logic       load_en;
  logic [1:0] load_addr;
  logic [7:0] load_data;
  assign bus.rdData1 = rf[bus.sr1];
  assign bus.rdData2 = rf[bus.sr2];

  always @(posedge clk) begin
    if (load_en) rf[load_addr] <= load_data;
    else if (bus.write) rf[bus.dr] <= bus.wrData;
  end

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  logic cur_z, cur_c;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest expected {dr, wrData}.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset && bus.write === 1'b1) begin
      check_eq("write_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wr_dr_data", 16'({bus.dr, bus.wrData}), 16'(e));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 16'(bus.instrReady), 16'd1);
    check_eq({tag, "_pulses"}, 16'({bus.write, bus.done}), 16'd0);
    check_eq({tag, "_addrs"}, 16'({bus.sr1, bus.sr2, bus.dr}), 16'd0);
    check_eq({tag, "_wrdata"}, 16'(bus.wrData), 16'd0);
    check_eq({tag, "_flags"}, 16'({bus.flagZ, bus.flagC}), 16'd0);
    check_eq({tag, "_state"}, 16'(state_dbg), 16'd0);
  endtask

  task automatic load_regs(input logic [31:0] regs);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 2'(i);
      load_data = regs[i*8 +: 8];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issue one instruction and check the pulse timing; wb is the cycle number of write-back.
  task automatic run_vec(input logic [7:0] ins, input int wb, input logic wr,
                         input logic z, input logic c);
    int bad;
    bad = 0;
    @(negedge clk);
    check_eq("ready_idle", 16'(bus.instrReady), 16'd1);
    bus.instrValid = 1'b1;
    bus.instr      = ins;
    @(posedge clk);
    for (int cyc = 1; cyc <= wb + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.instrValid = 1'b0;
        bus.instr      = ~ins;
        check_eq("read_addrs", 16'({bus.sr1, bus.sr2}), 16'({ins[3:2], ins[1:0]}));
      end
      if (cyc < wb) begin
        if (bus.instrReady !== 1'b0 || bus.write !== 1'b0 || bus.done !== 1'b0) bad++;
      end else if (cyc == wb) begin
        check_eq("wb_pulses", 16'({bus.done, bus.write, bus.instrReady}), 16'({1'b1, wr, 1'b0}));
      end else begin
        check_eq("after_ready_done", 16'({bus.instrReady, bus.done}), 16'b10);
        check_eq("after_flags", 16'({bus.flagZ, bus.flagC}), 16'({z, c}));
      end
    end
    check_eq("busy_window", 16'(bad), 16'd0);
  endtask

  typedef struct packed {
    logic [7:0]  ins;
    logic [31:0] regs;   // {r3, r2, r1, r0}
    logic        wr;
    logic [7:0]  data;
    logic        z;
    logic        c;
    logic        is_mul;
  } vec_t;

  vec_t vecs [14] = '{
    '{8'h06, 32'h00_20_F0_00, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0},  // ADD carry out
    '{8'hF0, 32'h00_20_F0_00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},  // NOP keeps C=1
    '{8'h15, 32'h00_00_05_00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0},  // SUB self
    '{8'h11, 32'h00_00_05_03, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0},  // SUB borrow
    '{8'h2B, 32'h3C_F0_00_00, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0},  // AND
    '{8'h31, 32'h00_00_A0_0F, 1'b1, 8'hAF, 1'b0, 1'b0, 1'b0},  // OR
    '{8'h4E, 32'h55_55_00_00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0},  // XOR to zero
    '{8'h58, 32'h00_FF_00_00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0},  // NOT
    '{8'h6C, 32'h81_00_00_00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0},  // SHL
    '{8'h74, 32'h00_00_01_00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0},  // SHR
    '{8'h89, 32'h00_77_00_00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0},  // MOV zero
    '{8'h9B, 32'h10_12_00_00, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1},  // MUL overflow
    '{8'h9E, 32'h0F_11_00_00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1},  // MUL fits
    '{8'hA5, 32'h01_02_03_04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}   // NOP
  };

  initial begin
    int bad;
    logic wr;
    int wb;
    reset          = 1'b1;
    bus.instrValid = 1'b0;
    bus.instr      = 8'h00;
    load_en        = 1'b0;
    load_addr      = 2'b00;
    load_data      = 8'h00;
    cur_z          = 1'b0;
    cur_c          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    foreach (vecs[i]) begin
      load_regs(vecs[i].regs);
      wr = vecs[i].wr;
      wb = 3;
`ifdef EXEC_MUL_EN
      if (vecs[i].is_mul) wb = 11;
`else
      if (vecs[i].is_mul) wr = 1'b0;
`endif
      if (wr) begin
        exp_q.push_back({vecs[i].ins[3:2], vecs[i].data});
        cur_z = vecs[i].z;
        cur_c = vecs[i].c;
      end
      run_vec(vecs[i].ins, wb, wr, cur_z, cur_c);
    end

    // Back-to-back: valid held high, second instruction taken at edge 4.
    load_regs(32'h00_20_F0_00);
    exp_q.push_back({2'd1, 8'h10});
    exp_q.push_back({2'd1, 8'h00});
    @(negedge clk);
    bus.instrValid = 1'b1;
    bus.instr      = 8'h06;
    @(posedge clk);
    bad = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.instr = 8'h26;
      if (cyc == 5) bus.instrValid = 1'b0;
      if ((cyc <= 3 || (cyc >= 5 && cyc <= 7)) && bus.instrReady !== 1'b0) bad++;
      if (cyc == 3) check_eq("b2b_first_write", 16'(bus.write), 16'd1);
      if (cyc == 4) begin
        check_eq("b2b_ready4", 16'(bus.instrReady), 16'd1);
        check_eq("b2b_flags4", 16'({bus.flagZ, bus.flagC}), 16'b01);
      end
      if (cyc == 6) check_eq("b2b_no_early", 16'({bus.write, bus.done}), 16'd0);
      if (cyc == 7) check_eq("b2b_second_write", 16'({bus.write, bus.done}), 16'b11);
      if (cyc == 8) check_eq("b2b_flags8", 16'({bus.flagZ, bus.flagC}), 16'b10);
    end
    check_eq("b2b_ready_low", 16'(bad), 16'd0);

    // Reset during EXEC discards the instruction.
    load_regs(32'h00_20_F0_00);
    @(negedge clk);
    bus.instrValid = 1'b1;
    bus.instr      = 8'h06;
    @(posedge clk);
    @(negedge clk);
    bus.instrValid = 1'b0;
    @(negedge clk);
    check_eq("rst_exec_state", 16'(state_dbg), 16'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_exec");
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.write !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check_eq("rst_exec_quiet", 16'(bad), 16'd0);

`ifdef EXEC_MUL_EN
    // Reset in MUL cycle 5.
    load_regs(32'h10_12_00_00);
    @(negedge clk);
    bus.instrValid = 1'b1;
    bus.instr      = 8'h9B;
    @(posedge clk);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.instrValid = 1'b0;
    end
    check_eq("rst_mul_state", 16'(state_dbg), 16'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_mul");
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.write !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check_eq("rst_mul_quiet", 16'(bad), 16'd0);
`endif

    // Recovery after reset.
    load_regs(32'h00_20_F0_00);
    exp_q.push_back({2'd1, 8'h10});
    run_vec(8'h06, 3, 1'b1, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    check_eq("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Multi-cycle execute/write-back stage for the 4×8-bit register file. It accepts one 8-bit instruction at a time and drives the register file's two read addresses. It captures the returned operands, computes the ALU result, then issues a single-cycle write of the result to the destination register. An optional sequential shift-add multiplier handles `MUL`.

## Interface
- No parameters; data width fixed at 8, register address width fixed at 2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instrValid` in 1: instruction present.
- `instr` in 8: `[7:4]` opcode, `[3:2]` rd (also first source), `[1:0]` rs.
- `instrReady` out 1: high only in IDLE; accept = `instrValid & instrReady` at rising edge.
- `sr1` out 2: register-file read address 1 = latched `instr[3:2]`.
- `sr2` out 2: register-file read address 2 = latched `instr[1:0]`.
- `rdData1` in 8: register-file read data 1 (combinational from `sr1`).
- `rdData2` in 8: register-file read data 2.
- `write` out 1: register-file write enable, one-cycle pulse.
- `dr` out 2: write address = latched `instr[3:2]`.
- `wrData` out 8: write data.
- `flagZ` out 1: registered zero flag.
- `flagC` out 1: registered carry/borrow flag.
- `done` out 1: one-cycle pulse on instruction completion.

## Operation
- FSM states: IDLE, READ, EXEC, MUL, WB.
- IDLE → READ on accept; latch `instr`.
- READ: `sr1`/`sr2` stable; capture `rdData1` → A and `rdData2` → B at end of cycle; → EXEC.
- EXEC: compute result R and carry into registers. `MUL` → MUL; all other opcodes → WB.
- MUL: 8 cycles of shift-add (A × B → 16-bit P); → WB.
- WB: `write` = 1 for writing opcodes, `done` = 1 always; → IDLE.
- Opcodes:
  - `0` ADD: R = A+B, C = carry-out.
  - `1` SUB: R = A−B mod 256, C = 1 iff A < B.
  - `2` AND, `3` OR, `4` XOR: C = 0.
  - `5` NOT: R = ~A, C = 0.
  - `6` SHL: R = A<<1, C = A[7].
  - `7` SHR: R = A>>1 logical, C = A[0].
  - `8` MOV: R = B, C = 0.
  - `9` MUL: R = P[7:0], C = (P[15:8] ≠ 0).
  - `A`–`F`: NOP, no write.
- Z = (R == 0).
- Flags update only in WB of a writing instruction; NOP leaves flags unchanged.
- `wrData`/`dr` hold the last values between writes; only `write` qualifies them.
- rd == rs is legal: both operands are read before any write.
- Reset (any state, including mid-MUL): next state IDLE; in-flight instruction discarded, no write.
- Reset values: `sr1`, `sr2`, `dr`, `wrData` = 0; `flagZ`, `flagC` = 0; `write`, `done` = 0; `instrReady` = 1.

## Timing
- Accept at edge 0 (cycle 0 is IDLE).
- Non-MUL instruction: READ in cycle 1, EXEC in cycle 2, WB in cycle 3 with `write`/`done` high.
- The register-file write commits at the end of cycle 3; `instrReady` returns high in cycle 4.
- Throughput: 1 instruction per 4 cycles.
- MUL: READ 1, EXEC 2, MUL 3–10, WB 11; next accept possible in cycle 12.
- `instrReady` is low from cycle 1 through WB inclusive. `instr` is ignored while `instrReady` is low.
- `done` and `write` are registered, coincident, and never high for more than one cycle per instruction.
- Flag outputs change at the end of the WB cycle and are visible from the following cycle.

## Configuration
- `EXEC_MUL_EN` defined: MUL state and the 8-cycle multiplier are compiled in; opcode `9` behaves as specified.
- `EXEC_MUL_EN` undefined: no MUL state and no multiplier logic. Opcode `9` is a NOP: EXEC → WB, `done` in cycle 3, `write` = 0, flags unchanged.

## Test plan
- ADD: R1 = 0xF0, R2 = 0x20, instr 0x06 → cycle 3: `write` = 1, `dr` = 1, `wrData` = 0x10; then C = 1, Z = 0.
- SUB self: R1 = 0x05, instr 0x15 → `wrData` = 0x00, Z = 1, C = 0; `write` in cycle 3.
- MUL: R2 = 0x12, R3 = 0x10, instr 0x9B.
  - With `EXEC_MUL_EN`: `write` in cycle 11, `dr` = 2, `wrData` = 0x20, C = 1.
  - Without it: `done` in cycle 3, `write` = 0, flags unchanged.
- Back-to-back: `instrValid` held high with instr 0x06 then 0x26 → `instrReady` low in cycles 1–3; second accepted at edge 4, its `write` in cycle 7.
- Reset mid-operation: assert `reset` for one cycle during EXEC (or during MUL cycle 5) → no `write`/`done` pulse. All outputs at reset values in the next cycle; `instrReady` = 1.
- NOP: instr 0xF0 after ADD leaving C = 1 → `done` in cycle 3, `write` = 0, `flagC` stays 1.
